// File: rtl/eth_tx_arbiter.sv
// Round-robin frame arbiter that shares one rgmii_tx MAC between N_REQ frame sources.
// Define ETH_TX_ARB_STATS_EN to enable the frame_cnt / trunc_cnt statistics counters.
module eth_tx_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned GAP_CYCLES  = 160
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [48*N_REQ-1:0]  req_dest,
  input  logic [16*N_REQ-1:0]  req_type,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 mac_phy_txen,
  output logic [7:0]           mac_phy_txd,
  output logic [47:0]          mac_dest,
  output logic [15:0]          ethertype,
  input  logic                 send_next,
  output logic                 underrun,
  output logic                 truncated,
  output logic [16*N_REQ-1:0]  frame_cnt,
  output logic [15:0]          trunc_cnt
);

  localparam int          NReq    = int'(N_REQ);
  localparam int unsigned IdxW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GapW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [10:0] LastCnt = 11'(MAX_PAYLOAD - 1);
  // GAP lasts GAP_CYCLES-1 cycles; the IDLE arbitration cycle makes up the full quiet gap.
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 2);

  typedef enum logic [2:0] {StIdle, StHdr, StStream, StDrain, StGap} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [47:0]       dest_q, dest_d;
  logic [15:0]       type_q, type_d;
  logic              txen_q, txen_d;
  logic [7:0]        txd_q, txd_d;
  logic [10:0]       byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              underrun_q, underrun_d;
  logic              truncated_q, truncated_d;

  logic [IdxW-1:0]   arb_idx;
  logic [N_REQ-1:0]  arb_onehot;
  logic [47:0]       arb_dest;
  logic [15:0]       arb_type;
  logic              own_req;
  logic              own_last;
  logic [7:0]        own_data;

  // First pending request at or after rr_q, wrapping; lower offsets win.
  always_comb begin
    arb_idx = '0;
    for (int k = NReq - 1; k >= 0; k--) begin
      for (int i = 0; i < NReq; i++) begin
        if (req[i] && (((int'(rr_q) + k) % NReq) == i)) begin
          arb_idx = IdxW'(i);
        end
      end
    end
    arb_onehot = '0;
    arb_dest   = '0;
    arb_type   = '0;
    for (int i = 0; i < NReq; i++) begin
      if (arb_idx == IdxW'(i)) begin
        arb_onehot[i] = 1'b1;
        arb_dest      = req_dest[48*i +: 48];
        arb_type      = req_type[16*i +: 16];
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NReq; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    dest_d      = dest_q;
    type_d      = type_q;
    txen_d      = txen_q;
    txd_d       = txd_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    underrun_d  = 1'b0;
    truncated_d = 1'b0;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        byte_cnt_d = '0;
        if (|req) begin
          owner_d = arb_idx;
          grant_d = arb_onehot;
          dest_d  = arb_dest;
          type_d  = arb_type;
          txen_d  = 1'b1;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (!own_req) begin
          underrun_d = 1'b1;
          state_d    = StDrain;
        end else if (send_next) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (send_next) begin
          if (!own_req) begin
            underrun_d = 1'b1;
            state_d    = StDrain;
          end else begin
            req_ready  = grant_q;
            txd_d      = own_data;
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (own_last || (byte_cnt_q == LastCnt)) begin
              truncated_d = !own_last;
              state_d     = StDrain;
            end
          end
        end
      end
      StDrain: begin
        txen_d    = 1'b0;
        grant_d   = '0;
        gap_cnt_d = '0;
        rr_d      = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      dest_q      <= '0;
      type_q      <= '0;
      txen_q      <= 1'b0;
      txd_q       <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      dest_q      <= dest_d;
      type_q      <= type_d;
      txen_q      <= txen_d;
      txd_q       <= txd_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      underrun_q  <= underrun_d;
      truncated_q <= truncated_d;
    end
  end

  assign grant        = grant_q;
  assign mac_phy_txen = txen_q;
  assign mac_phy_txd  = txd_q;
  assign mac_dest     = dest_q;
  assign ethertype    = type_q;
  assign underrun     = underrun_q;
  assign truncated    = truncated_q;

`ifdef ETH_TX_ARB_STATS_EN
  logic [16*N_REQ-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]         trunc_cnt_q, trunc_cnt_d;
  logic                drain_entry;

  assign drain_entry = (state_d == StDrain) && (state_q != StDrain);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    for (int i = 0; i < NReq; i++) begin
      if (drain_entry && (owner_q == IdxW'(i)) && (frame_cnt_q[16*i +: 16] != 16'hFFFF)) begin
        frame_cnt_d[16*i +: 16] = frame_cnt_q[16*i +: 16] + 16'd1;
      end
    end
    if ((underrun_d || truncated_d) && (trunc_cnt_q != 16'hFFFF)) begin
      trunc_cnt_d = trunc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
`else
  assign frame_cnt = '0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: requester models, MAC pacing, grant/byte queues.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
  localparam int NREQ = 2;
  localparam int MAXP = 1500;
  localparam int GAP  = 160;

  logic                clk, rst_n;
  logic [NREQ-1:0]     req, req_last, req_ready, grant;
  logic [48*NREQ-1:0]  req_dest;
  logic [16*NREQ-1:0]  req_type;
  logic [8*NREQ-1:0]   req_data;
  logic                mac_phy_txen, send_next, underrun, truncated;
  logic [7:0]          mac_phy_txd;
  logic [47:0]         mac_dest;
  logic [15:0]         ethertype;
  logic [16*NREQ-1:0]  frame_cnt;
  logic [15:0]         trunc_cnt;

  eth_tx_arbiter #(.N_REQ(NREQ), .MAX_PAYLOAD(MAXP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_type(req_type),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .mac_phy_txen(mac_phy_txen), .mac_phy_txd(mac_phy_txd), .mac_dest(mac_dest),
    .ethertype(ethertype), .send_next(send_next), .underrun(underrun),
    .truncated(truncated), .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input int f, input int k);
    return 8'(i * 128 + f * 32 + k);
  endfunction

  // Requester and MAC model state
  int          rq_len[NREQ], rq_idx[NREQ], rq_frame[NREQ], rq_frames[NREQ], rq_drop[NREQ];
  bit          rq_nolast[NREQ];
  logic [47:0] rq_dest[NREQ];
  logic [15:0] rq_type[NREQ];
  bit          sn_always;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [47:0]     d;
    logic [15:0]     t;
  } gnt_t;
  logic [7:0] exp_q[$];
  gnt_t       gnt_q[$];
  gnt_t       gexp;

  task automatic push_frame(input int i, input int f, input int nbytes);
    gnt_t e;
    e.g    = '0;
    e.g[i] = 1'b1;
    e.d    = rq_dest[i];
    e.t    = rq_type[i];
    gnt_q.push_back(e);
    for (int k = 0; k < nbytes; k++) exp_q.push_back(pat(i, f, k));
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      rq_frames[i] = 0;
      rq_idx[i]    = 0;
      rq_frame[i]  = 0;
      rq_drop[i]   = -1;
      rq_nolast[i] = 1'b0;
    end
  endtask

  logic [NREQ-1:0] rdy_s, grant_s;
  logic            trunc_s;

  initial begin
    clear_model();
    for (int i = 0; i < NREQ; i++) begin
      rq_len[i]  = 1;
      rq_dest[i] = '0;
      rq_type[i] = '0;
    end
    sn_always = 1'b0;
    req = '0; req_last = '0; req_data = '0; req_dest = '0; req_type = '0; send_next = 1'b0;
    forever begin
      @(negedge clk);
      rdy_s   = req_ready;
      grant_s = grant;
      trunc_s = truncated;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_s[i]) begin
          rq_idx[i]++;
          if (!rq_nolast[i] && rq_idx[i] == rq_len[i]) begin
            rq_idx[i] = 0;
            rq_frame[i]++;
            rq_frames[i]--;
          end else if (rq_idx[i] == rq_drop[i]) begin
            rq_idx[i]    = 0;
            rq_frames[i] = 0;
          end
        end
        if (trunc_s && grant_s[i]) begin
          rq_idx[i] = 0;
          rq_frame[i]++;
          rq_frames[i]--;
        end
        req[i]                = rq_frames[i] > 0;
        req_data[8*i +: 8]    = pat(i, rq_frame[i], rq_idx[i]);
        req_last[i]           = !rq_nolast[i] && (rq_idx[i] == rq_len[i] - 1);
        req_dest[48*i +: 48]  = rq_dest[i];
        req_type[16*i +: 16]  = rq_type[i];
      end
      send_next = sn_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor
  int cyc = 0, frames_done = 0, ready_cnt = 0, last_ready_cnt = 0, last_rdy_t = 0;
  int fall_lat = 0, urun_lat = 0, drop_t = 0, lowcnt = 0, urun_cnt = 0, trunc_pulses = 0;
  bit chk_gap = 1'b0, had_frame = 1'b0, pend = 1'b0;
  logic [NREQ-1:0] grant_prev = '0, cur_grant = '0, req_prev = '0;
  logic            txen_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; grant_prev = '0; txen_prev = 1'b0; lowcnt = 0; had_frame = 1'b0;
        ready_cnt = 0; req_prev = '0;
      end else begin
        if (pend) begin
          if (exp_q.size() == 0) check_eq("txd_extra", exp_q.size(), 1);
          else check_eq("txd", mac_phy_txd, exp_q.pop_front());
        end
        pend = |req_ready;
        if (grant != '0 && grant_prev == '0) begin
          if (chk_gap && had_frame) check_eq("gap_len", lowcnt, GAP);
          check_eq("txen_at_grant", mac_phy_txen, 1);
          if (gnt_q.size() == 0) check_eq("grant_extra", gnt_q.size(), 1);
          else begin
            gexp = gnt_q.pop_front();
            check_eq("grant", grant, gexp.g);
            check_eq("dest", mac_dest, gexp.d);
            check_eq("type", ethertype, gexp.t);
          end
          cur_grant = grant;
          ready_cnt = 0;
        end else if (grant != '0) begin
          check_eq("grant_hold", grant, cur_grant);
        end
        if (|req_ready) begin
          check_eq("rdy_own", req_ready, grant);
          ready_cnt++;
          last_rdy_t = cyc;
        end
        if (txen_prev && !mac_phy_txen) begin
          frames_done++;
          last_ready_cnt = ready_cnt;
          fall_lat       = cyc - last_rdy_t;
          urun_lat       = cyc - drop_t;
          had_frame      = 1'b1;
        end
        if (mac_phy_txen) lowcnt = 0;
        else lowcnt++;
        if (underrun) urun_cnt++;
        if (truncated) trunc_pulses++;
        if ((req_prev & cur_grant) != '0 && (req & cur_grant) == '0 && grant != '0) drop_t = cyc;
        req_prev   = req;
        grant_prev = grant;
        txen_prev  = mac_phy_txen;
      end
      cyc++;
    end
  end

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, frames_done >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    clear_model();
    exp_q.delete();
    gnt_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base, u0, t0, n, exp_f0, exp_tc;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_txen", mac_phy_txen, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_txd", mac_phy_txd, 0);
    check_eq("rst_dest", mac_dest, 0);
    check_eq("rst_flags", {underrun, truncated}, 0);
    check_eq("rst_stats", {frame_cnt, trunc_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 46-byte frame on port 0
    rq_dest[0] = 48'h0A0B0C0D0E0F; rq_type[0] = 16'h0806;
    rq_dest[1] = 48'h112233445566; rq_type[1] = 16'h0800;
    rq_len[0] = 46; sn_always = 1'b0;
    push_frame(0, rq_frame[0], 46);
    rq_frames[0] = 1;
    wait_frames(1, 2000, "single_done");
    check_eq("single_rdy", last_ready_cnt, 46);
    check_eq("single_fall", fall_lat, 2);

    // Truncation: 1600 bytes with no last marker
    sn_always = 1'b1; rq_len[0] = 1600; rq_nolast[0] = 1'b1; t0 = trunc_pulses;
    push_frame(0, rq_frame[0], MAXP);
    rq_frames[0] = 1;
    wait_frames(2, 4000, "trunc_done");
    check_eq("trunc_rdy", last_ready_cnt, MAXP);
    check_eq("trunc_fall", fall_lat, 2);
    check_eq("trunc_pulse", trunc_pulses - t0, 1);
    rq_nolast[0] = 1'b0;

    // Third frame on port 0, then statistics
    rq_len[0] = 5; sn_always = 1'b0;
    push_frame(0, rq_frame[0], 5);
    rq_frames[0] = 1;
    wait_frames(3, 1000, "third_done");
    check_eq("third_rdy", last_ready_cnt, 5);
`ifdef ETH_TX_ARB_STATS_EN
    exp_f0 = 3; exp_tc = 1;
`else
    exp_f0 = 0; exp_tc = 0;
`endif
    check_eq("stat_frames0", frame_cnt[15:0], exp_f0);
    check_eq("stat_frames1", frame_cnt[31:16], 0);
    check_eq("stat_trunc", trunc_cnt, exp_tc);

    // Contention: both ports, three frames each, back to back
    do_reset();
    rq_len[0] = 20; rq_len[1] = 12; chk_gap = 1'b1; base = frames_done;
    for (int f = 0; f < 3; f++) begin
      push_frame(0, f, 20);
      push_frame(1, f, 12);
    end
    rq_frames[0] = 3; rq_frames[1] = 3;
    wait_frames(base + 6, 8000, "cont_done");
    check_eq("cont_grants_left", gnt_q.size(), 0);

    // Underrun: port 1 drops after 10 bytes, port 0 waits out the gap
    sn_always = 1'b1; rq_len[1] = 50; rq_drop[1] = 10; u0 = urun_cnt; base = frames_done;
    push_frame(1, rq_frame[1], 10);
    rq_frames[1] = 1;
    n = 0;
    while (urun_cnt == u0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("urun_seen", urun_cnt > u0, 1);
    wait_frames(base + 1, 10, "urun_fall");
    check_eq("urun_rdy", last_ready_cnt, 10);
    check_eq("urun_lat", urun_lat, 2);
    rq_drop[1] = -1; rq_len[0] = 8;
    push_frame(0, rq_frame[0], 8);
    rq_frames[0] = 1;
    wait_frames(base + 2, 1000, "post_urun_done");
    check_eq("urun_once", urun_cnt - u0, 1);

    // Asynchronous reset mid-stream
    chk_gap = 1'b0; rq_len[0] = 200;
    push_frame(0, rq_frame[0], 200);
    rq_frames[0] = 1;
    n = 0;
    while (!(mac_phy_txen && ready_cnt >= 20) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ares_streaming", ready_cnt >= 20, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ares_txen", mac_phy_txen, 0);
    check_eq("ares_grant", grant, 0);
    check_eq("ares_ready", req_ready, 0);
    @(posedge clk);
    #2;
    clear_model();
    exp_q.delete();
    gnt_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ares_stats", {frame_cnt, trunc_cnt}, 0);
    // rr pointer must be back at 0: port 0 wins the tie
    rq_len[0] = 4; rq_len[1] = 4; base = frames_done;
    push_frame(0, 0, 4);
    push_frame(1, 0, 4);
    rq_frames[0] = 1; rq_frames[1] = 1;
    wait_frames(base + 2, 2000, "ares_rr_done");
    check_eq("end_bytes_left", exp_q.size(), 0);
    check_eq("end_grants_left", gnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
